// File: rtl/param_reg_file_pkg.sv
// ----------------------------------------------------------------------------
// param_reg_pkg
// Shared types and defaults for the parametrised register file.
//   clr_state_t    : soft-clear sequencer states
//   PRF_DATA_WIDTH : default register width
//   PRF_ADDR_WIDTH : default address width (DEPTH = 2**ADDR_WIDTH)
// ----------------------------------------------------------------------------
package param_reg_pkg;

    localparam int PRF_DATA_WIDTH = 8;
    localparam int PRF_ADDR_WIDTH = 3;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } clr_state_t;

endpackage : param_reg_pkg

// File: rtl/param_reg_file_if.sv
// ----------------------------------------------------------------------------
// param_reg_file_if
// Bus bundle between the control unit / ALU and the register file.
//   IN, INADDRESS, WRITE     : write port
//   OUT1ADDRESS, OUT2ADDRESS : read addresses
//   CLEAR                    : soft-clear request
//   OUT1, OUT2               : read data (combinational)
//   BUSY, WRITE_ERR          : status
// master = requester side, slave = register file side.
// ----------------------------------------------------------------------------
interface param_reg_file_if #(
    parameter int DATA_WIDTH = param_reg_pkg::PRF_DATA_WIDTH,
    parameter int ADDR_WIDTH = param_reg_pkg::PRF_ADDR_WIDTH
);

    logic [DATA_WIDTH-1:0] IN;
    logic [ADDR_WIDTH-1:0] INADDRESS;
    logic                  WRITE;
    logic [ADDR_WIDTH-1:0] OUT1ADDRESS;
    logic [ADDR_WIDTH-1:0] OUT2ADDRESS;
    logic                  CLEAR;
    logic [DATA_WIDTH-1:0] OUT1;
    logic [DATA_WIDTH-1:0] OUT2;
    logic                  BUSY;
    logic                  WRITE_ERR;

    modport master (
        output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
        input  OUT1, OUT2, BUSY, WRITE_ERR
    );

    modport slave (
        input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
        output OUT1, OUT2, BUSY, WRITE_ERR
    );

endinterface : param_reg_file_if

// File: rtl/param_reg_file_clear_seq.sv
// ----------------------------------------------------------------------------
// reg_clear_seq
// Soft-clear sequencer: walks a pointer over every entry, one per cycle.
//   clk_i, rst_n_i : clock, async active-low reset
//   clear_i        : clear request (only honoured in IDLE)
//   busy_o         : registered, high for exactly DEPTH cycles
//   clr_stb_o      : zero the entry at clr_addr_o on this edge
//   clr_addr_o     : entry being cleared
//
// state    | meaning
// IDLE     | no clear in progress, writes allowed
// CLEARING | zeroing entry ptr_q each edge, writes dropped
// ----------------------------------------------------------------------------
module reg_clear_seq
    import param_reg_pkg::*;
#(
    parameter int ADDR_WIDTH = PRF_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clear_i,
    output logic                  busy_o,
    output logic                  clr_stb_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = {ADDR_WIDTH{1'b1}};

    clr_state_t            state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic                  busy_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_i) begin
                        state_q <= CLEARING;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEARING: begin
                    // CLEAR is ignored here, so the sequence never restarts or stretches.
                    if (ptr_q == LAST_PTR) begin
                        state_q <= IDLE;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ptr_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_stb_o  = (state_q == CLEARING);
    assign clr_addr_o = ptr_q;

endmodule : reg_clear_seq

// File: rtl/param_reg_file.sv
// ----------------------------------------------------------------------------
// param_reg_file
// 2**ADDR_WIDTH x DATA_WIDTH register file, one write port, two async reads,
// optional write bypass, optional hardwired zero entry, soft clear.
//   CLK     : rising-edge clock
//   RESET_N : async active-low reset
//   bus     : param_reg_file_if.slave (write/read/clear inputs, data/status out)
// ----------------------------------------------------------------------------
module param_reg_file
    import param_reg_pkg::*;
#(
    parameter int DATA_WIDTH = PRF_DATA_WIDTH,
    parameter int ADDR_WIDTH = PRF_ADDR_WIDTH,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    param_reg_file_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  busy;
    logic                  clr_stb;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_zero;
    logic                  wr_acc;
    logic                  write_err_d;
    logic                  write_err_q;

    reg_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clk_i      (CLK),
        .rst_n_i    (RESET_N),
        .clear_i    (bus.CLEAR),
        .busy_o     (busy),
        .clr_stb_o  (clr_stb),
        .clr_addr_o (clr_addr)
    );

    // Writes to a hardwired zero entry vanish silently; they are not errors.
    always_comb begin
        wr_zero     = (ZERO_REG != 0) && (bus.INADDRESS == '0);
        wr_acc      = bus.WRITE && !busy && !bus.CLEAR && !wr_zero;
        write_err_d = bus.WRITE && (busy || bus.CLEAR) && !wr_zero;
    end

    // Clear strobe and accepted write are mutually exclusive (wr_acc needs !busy).
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_stb) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_acc) begin
            mem_q[bus.INADDRESS] <= bus.IN;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            write_err_q <= 1'b0;
        end else begin
            write_err_q <= write_err_d;
        end
    end

    // Zero entry wins over bypass; bypass only forwards writes that will land.
    function automatic logic [DATA_WIDTH-1:0] read_mux(
        input logic [ADDR_WIDTH-1:0] raddr,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  acc,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata
    );
        logic [DATA_WIDTH-1:0] rd;
        rd = stored;
        if ((BYPASS != 0) && acc && (waddr == raddr)) begin
            rd = wdata;
        end
        if ((ZERO_REG != 0) && (raddr == '0)) begin
            rd = '0;
        end
        return rd;
    endfunction

    assign bus.OUT1      = read_mux(bus.OUT1ADDRESS, mem_q[bus.OUT1ADDRESS],
                                    wr_acc, bus.INADDRESS, bus.IN);
    assign bus.OUT2      = read_mux(bus.OUT2ADDRESS, mem_q[bus.OUT2ADDRESS],
                                    wr_acc, bus.INADDRESS, bus.IN);
    assign bus.BUSY      = busy;
    assign bus.WRITE_ERR = write_err_q;

endmodule : param_reg_file

// File: tb/tb_param_reg_file.sv
module tb_param_reg_file;

    logic CLK;
    logic RESET_N;

    int n_chk;
    int n_err;

    param_reg_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) if_byp ();
    param_reg_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) if_nob ();
    param_reg_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) if_zr  ();
    param_reg_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_wd  ();

    param_reg_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1), .ZERO_REG(0))
        u_byp (.CLK(CLK), .RESET_N(RESET_N), .bus(if_byp));
    param_reg_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(0), .ZERO_REG(0))
        u_nob (.CLK(CLK), .RESET_N(RESET_N), .bus(if_nob));
    param_reg_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1), .ZERO_REG(1))
        u_zr  (.CLK(CLK), .RESET_N(RESET_N), .bus(if_zr));
    param_reg_file #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .BYPASS(1), .ZERO_REG(0))
        u_wd  (.CLK(CLK), .RESET_N(RESET_N), .bus(if_wd));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic clr, input logic [3:0] ra1, input logic [3:0] ra2);
        if_byp.WRITE = we; if_byp.INADDRESS = wa[2:0]; if_byp.IN = wd; if_byp.CLEAR = clr;
        if_byp.OUT1ADDRESS = ra1[2:0]; if_byp.OUT2ADDRESS = ra2[2:0];
        if_nob.WRITE = we; if_nob.INADDRESS = wa[2:0]; if_nob.IN = wd; if_nob.CLEAR = clr;
        if_nob.OUT1ADDRESS = ra1[2:0]; if_nob.OUT2ADDRESS = ra2[2:0];
        if_zr.WRITE  = we; if_zr.INADDRESS  = wa[2:0]; if_zr.IN  = wd; if_zr.CLEAR  = clr;
        if_zr.OUT1ADDRESS  = ra1[2:0]; if_zr.OUT2ADDRESS  = ra2[2:0];
        if_wd.WRITE  = we; if_wd.INADDRESS  = wa;      if_wd.IN  = wd; if_wd.CLEAR  = clr;
        if_wd.OUT1ADDRESS  = ra1;      if_wd.OUT2ADDRESS  = ra2;
    endtask

    // One rising edge passes; returns at the following falling edge.
    task automatic step();
        @(negedge CLK);
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        RESET_N = 1'b0;
        drv(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        chk("rst_out1",    if_byp.OUT1, 8'h00);
        chk("rst_out2",    if_byp.OUT2, 8'h00);
        chk("rst_busy",    8'(if_byp.BUSY), 8'h00);
        chk("rst_werr",    8'(if_byp.WRITE_ERR), 8'h00);

        // basic write / read
        drv(1'b1, 4'd3, 8'h5A, 1'b0, 4'd3, 4'd7);
        step();
        chk("wr_r3_byp",   if_byp.OUT1, 8'h5A);
        chk("wr_r3_nob",   if_nob.OUT1, 8'h5A);
        drv(1'b1, 4'd7, 8'hC3, 1'b0, 4'd3, 4'd7);
        step();
        drv(1'b1, 4'd2, 8'h44, 1'b0, 4'd3, 4'd7);
        #1;
        chk("wr_r7_byp",   if_byp.OUT2, 8'hC3);
        chk("wr_r7_nob",   if_nob.OUT2, 8'hC3);
        step();

        // bypass vs no bypass
        drv(1'b1, 4'd2, 8'h11, 1'b0, 4'd2, 4'd7);
        #1;
        chk("byp_fwd",     if_byp.OUT1, 8'h11);
        chk("nobyp_old",   if_nob.OUT1, 8'h44);
        step();
        drv(1'b0, 4'd0, 8'h00, 1'b0, 4'd2, 4'd7);
        #1;
        chk("nobyp_after", if_nob.OUT1, 8'h11);

        // async reset mid-cycle
        drv(1'b0, 4'd0, 8'h00, 1'b0, 4'd3, 4'd7);
        #1;
        chk("pre_rst_r3",  if_byp.OUT1, 8'h5A);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("arst_out1",   if_byp.OUT1, 8'h00);
        chk("arst_out2",   if_nob.OUT2, 8'h00);
        @(negedge CLK);
        RESET_N = 1'b1;

        // soft clear with preload 1..8
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, 4'(i), 8'(i + 1), 1'b0, 4'd0, 4'd7);
            step();
        end
        drv(1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 4'd7);
        step();                                        // edge k
        drv(1'b1, 4'd4, 8'hFF, 1'b1, 4'd4, 4'd7);
        #1;
        chk("clr_busy_k",  8'(if_byp.BUSY), 8'h01);
        chk("clr_nobyp_drop", if_byp.OUT1, 8'h05);
        chk("clr_r7_k",    if_byp.OUT2, 8'h08);
        step();                                        // k+1
        chk("drop_busy_err", 8'(if_byp.WRITE_ERR), 8'h01);
        drv(1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 4'd7);
        #1;
        chk("clr_r0_k1",   if_byp.OUT1, 8'h00);
        chk("clr_r7_k1",   if_byp.OUT2, 8'h08);
        step();                                        // k+2
        chk("err_pulse",   8'(if_byp.WRITE_ERR), 8'h00);
        for (int j = 3; j <= 7; j++) begin
            step();
            chk("clr_busy_mid", 8'(if_byp.BUSY), 8'h01);
            chk("clr_r7_mid",   if_byp.OUT2, 8'h08);
        end
        drv(1'b0, 4'd0, 8'h00, 1'b0, 4'd4, 4'd7);
        step();                                        // k+8
        chk("clr_busy_end", 8'(if_byp.BUSY), 8'h00);
        chk("clr_r7_end",   if_byp.OUT2, 8'h00);
        chk("clr_r4_end",   if_byp.OUT1, 8'h00);
        chk("wide_busy_k8", 8'(if_wd.BUSY), 8'h01);
        repeat (7) step();                             // k+15
        chk("wide_busy_k15", 8'(if_wd.BUSY), 8'h01);
        step();                                        // k+16
        chk("wide_busy_k16", 8'(if_wd.BUSY), 8'h00);

        // CLEAR + WRITE together, then reset mid-clear
        drv(1'b1, 4'd5, 8'h66, 1'b0, 4'd5, 4'd7);
        step();
        drv(1'b1, 4'd7, 8'h77, 1'b0, 4'd5, 4'd7);
        step();
        drv(1'b1, 4'd6, 8'h99, 1'b1, 4'd6, 4'd6);
        #1;
        chk("clrwr_nobyp", if_byp.OUT1, 8'h00);
        step();                                        // edge k'
        chk("clrwr_err",   8'(if_byp.WRITE_ERR), 8'h01);
        chk("clrwr_busy",  8'(if_byp.BUSY), 8'h01);
        chk("clrwr_r6",    if_byp.OUT1, 8'h00);
        drv(1'b0, 4'd0, 8'h00, 1'b0, 4'd5, 4'd7);
        repeat (3) step();                             // k'+3
        chk("mid_r5",      if_byp.OUT1, 8'h66);
        chk("mid_r7",      if_byp.OUT2, 8'h77);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("midrst_busy", 8'(if_byp.BUSY), 8'h00);
        chk("midrst_r5",   if_byp.OUT1, 8'h00);
        chk("midrst_r7",   if_byp.OUT2, 8'h00);
        @(negedge CLK);
        RESET_N = 1'b1;
        drv(1'b1, 4'd5, 8'h22, 1'b0, 4'd5, 4'd7);
        step();
        drv(1'b0, 4'd0, 8'h00, 1'b0, 4'd5, 4'd7);
        #1;
        chk("post_rst_r5", if_byp.OUT1, 8'h22);
        chk("post_rst_busy", 8'(if_byp.BUSY), 8'h00);
        chk("post_rst_err", 8'(if_byp.WRITE_ERR), 8'h00);

        // hardwired zero entry
        drv(1'b1, 4'd0, 8'h77, 1'b0, 4'd0, 4'd0);
        #1;
        chk("zr_byp",      if_zr.OUT1, 8'h00);
        chk("nz_byp_r0",   if_byp.OUT1, 8'h77);
        step();
        drv(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0);
        #1;
        chk("zr_r0",       if_zr.OUT1, 8'h00);
        chk("zr_err",      8'(if_zr.WRITE_ERR), 8'h00);
        chk("nz_r0",       if_byp.OUT1, 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_param_reg_file

// File: doc/param_reg_file.md
Name: param_reg_file

Overview:
- Parametrised register file for the CPU datapath: 2^ADDR_WIDTH entries of DATA_WIDTH bits, one write port and two asynchronous read ports.
- Adds behaviour the 8x8 file does not have:
  - optional write-to-read bypass;
  - optional hardwired zero register;
  - a soft-clear sequencer that zeroes one entry per cycle while asserting BUSY;
  - a write-error flag for writes that are dropped.
- Sits between the control unit/ALU result bus and the ALU operand muxes.

Parameters:
- DATA_WIDTH, 8, width of each register and of IN/OUT1/OUT2.
- ADDR_WIDTH, 3, address width; DEPTH = 2^ADDR_WIDTH entries.
- BYPASS, 1, when 1 a same-cycle accepted write is forwarded to matching read ports.
- ZERO_REG, 0, when 1 entry 0 always reads 0 and writes to it are discarded (discarded writes do not raise WRITE_ERR).

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous, active-low reset.
- IN  input  DATA_WIDTH  write data.
- INADDRESS  input  ADDR_WIDTH  write address.
- WRITE  input  1  write enable, sampled on rising CLK.
- OUT1ADDRESS  input  ADDR_WIDTH  read port 1 address.
- OUT2ADDRESS  input  ADDR_WIDTH  read port 2 address.
- CLEAR  input  1  soft-clear request, sampled on rising CLK.
- OUT1  output  DATA_WIDTH  read port 1 data (combinational).
- OUT2  output  DATA_WIDTH  read port 2 data (combinational).
- BUSY  output  1  high while the soft-clear sequence runs.
- WRITE_ERR  output  1  registered one-cycle pulse: the previous edge's WRITE was dropped.

Behaviour:
- Reset (RESET_N low, asynchronous, takes effect immediately):
  - all entries 0, FSM IDLE, clear pointer 0;
  - BUSY 0, WRITE_ERR 0, OUT1/OUT2 therefore 0.
  - Reset mid-clear aborts the sequence.
  - Release is synchronous to the next edge; no write is accepted on an edge where RESET_N is low.
- Write (IDLE, CLEAR low, WRITE high): register[INADDRESS] <= IN at the rising edge. Latency 1 edge; no internal delays.
- Read:
  - OUTx = register[OUTxADDRESS], combinational, zero cycles.
  - Both ports may address the same entry.
- Bypass (BYPASS=1):
  - if a write will be accepted this cycle and INADDRESS == OUTxADDRESS, then OUTx = IN;
  - a dropped write is never bypassed.
- Zero register (ZERO_REG=1): OUTx = 0 whenever OUTxADDRESS == 0, including under bypass.
- FSM states: IDLE, CLEARING.
  - IDLE: CLEAR high at edge k -> CLEARING, ptr <= 0, BUSY high from edge k.
  - CLEARING: each edge, register[ptr] <= 0 and ptr <= ptr+1.
    - Entries are cleared at edges k+1..k+DEPTH.
    - At the edge clearing entry DEPTH-1 -> IDLE and BUSY low. BUSY is high for exactly DEPTH cycles.
  - During CLEARING, reads return current contents: cleared entries 0, uncleared entries their old value.
- Dropped writes (WRITE_ERR high for exactly the cycle after the edge):
  - WRITE high while BUSY;
  - WRITE and CLEAR high together in IDLE (CLEAR has priority).
- CLEAR while BUSY: ignored; the sequence does not restart or extend.
- Pointer wrap: ptr is ADDR_WIDTH bits; the end condition is ptr == DEPTH-1, so there is no overflow state.
- WRITE_ERR is registered and cleared on the following edge unless a new drop occurs, so back-to-back drops keep it high.

Decomposition:
- Package param_reg_pkg:
  - FSM state enum (IDLE, CLEARING);
  - default DATA_WIDTH/ADDR_WIDTH constants.
- Sub-module reg_clear_seq contains:
  - CLEAR FSM;
  - pointer;
  - BUSY;
  - per-cycle clear strobe and address.
- Top-level module contains:
  - storage array;
  - write arbitration;
  - bypass and zero muxes;
  - WRITE_ERR register.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=3 unless noted):
- Reset/write/read:
  - Pulse RESET_N low mid-cycle -> all outputs 0 immediately.
  - Write 0x5A to r3 and 0xC3 to r7.
  - Set OUT1ADDRESS=3, OUT2ADDRESS=7 -> OUT1=0x5A and OUT2=0xC3 the cycle after each write.
- Bypass (BYPASS=1):
  - Drive WRITE=1, INADDRESS=2, IN=0x11, OUT1ADDRESS=2 -> OUT1=0x11 before the edge.
  - With BYPASS=0 -> OUT1 keeps its old r2 value until after the edge.
- Soft clear:
  - Preload r0..r7 = 1..8; CLEAR=1 at edge k.
  - BUSY is high for 8 cycles.
  - r0 reads 0 after k+1 while r7 still reads 8 until k+8.
  - BUSY is low after k+8.
- Dropped writes:
  - WRITE to r4 (0xFF) during BUSY -> WRITE_ERR=1 for one cycle, r4=0 after the clear.
  - CLEAR and WRITE together in IDLE -> write dropped, WRITE_ERR=1.
  - CLEAR reasserted while BUSY -> BUSY still falls at k+8.
- Reset mid-clear:
  - Drop RESET_N at k+3 -> BUSY=0, all entries 0, FSM IDLE.
  - Write 0x22 to r5 next cycle -> OUT1 reads 0x22.
- ZERO_REG=1:
  - Write 0x77 to r0 -> OUT1ADDRESS=0 reads 0 (bypass too), WRITE_ERR stays 0.
  - ADDR_WIDTH=4 variant: a clear lasts 16 cycles.
